// File: rtl/rv32i_exec_ctrl.sv
// ---------------------------------------------------------------------------
// rv32i_exec_ctrl
//   RV32I execute stage: instruction decode, branch comparator and ALU in one
//   unit. All of them evaluate combinationally from the current inputs, and
//   every output is captured in a register. Results therefore appear one
//   cycle after the inputs are presented.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      synchronous active-low reset; clears every output register
//   i_valid      inputs valid this cycle
//   i_inst       instruction word
//   i_pc         PC of the instruction
//   i_rs1_data   rs1 value
//   i_rs2_data   rs2 value
//   i_imm        sign-extended immediate from immgen
//   o_valid      registered i_valid
//   o_alu_data   ALU result (address, target or writeback value)
//   o_pc_sel     1 = next PC is o_alu_data
//   o_rd_wren    regfile write enable
//   o_mem_wren   store enable
//   o_wb_sel     00 ALU, 01 none, 10 PC+4, 11 load data
//   o_br_less    comparator less-than
//   o_br_equal   comparator equal
//   o_illegal    unsupported opcode/funct
//   o_alu_zero   (only with RV32I_ALU_ZERO_EN) registered o_alu_data == 0
//
// Build option
//   RV32I_ALU_ZERO_EN  adds the o_alu_zero output.
// ---------------------------------------------------------------------------
module rv32i_exec_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm,
  output logic            o_valid,
  output logic [XLEN-1:0] o_alu_data,
  output logic            o_pc_sel,
  output logic            o_rd_wren,
  output logic            o_mem_wren,
  output logic [1:0]      o_wb_sel,
  output logic            o_br_less,
  output logic            o_br_equal,
`ifdef RV32I_ALU_ZERO_EN
  output logic            o_alu_zero,
`endif
  output logic            o_illegal
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            f7_b5;
  logic            unused_inst_bits;

  logic [XLEN-1:0] op1, op2, alu_res, alu_final;
  alu_op_e         alu_op;
  logic            rd_wren, mem_wren, pc_sel, illegal, jalr;
  logic [1:0]      wb_sel;
  logic            br_less, br_equal, br_taken;

  assign opcode = i_inst[6:0];
  assign funct3 = i_inst[14:12];
  assign f7_b5  = i_inst[30];

  // Register specifiers and the rest of funct7 are consumed upstream.
  assign unused_inst_bits = &{1'b0, i_inst[31], i_inst[29:15], i_inst[11:7]};

  // Comparator: always rs1 vs rs2; the unsigned form is picked by
  // funct3 11x (bltu/bgeu), the signed form otherwise.
  always_comb begin
    br_equal = (i_rs1_data == i_rs2_data);
    if (funct3[2:1] == 2'b11)
      br_less = (i_rs1_data < i_rs2_data);
    else
      br_less = ($signed(i_rs1_data) < $signed(i_rs2_data));
  end

  // Branch condition from funct3. 010/011 never take; decode flags them.
  always_comb begin
    case (funct3)
      3'b000:          br_taken = br_equal;
      3'b001:          br_taken = ~br_equal;
      3'b100, 3'b110:  br_taken = br_less;
      3'b101, 3'b111:  br_taken = ~br_less;
      default:         br_taken = 1'b0;
    endcase
  end

  // Decode: operand selection, ALU operation and control enables.
  // Everything not an R/I op computes an address or target with ADD.
  always_comb begin
    op1      = i_rs1_data;
    op2      = i_imm;
    alu_op   = ALU_ADD;
    rd_wren  = 1'b0;
    mem_wren = 1'b0;
    pc_sel   = 1'b0;
    wb_sel   = 2'b01;
    illegal  = 1'b0;
    jalr     = 1'b0;
    case (opcode)
      OP_R, OP_I: begin
        if (opcode == OP_R) op2 = i_rs2_data;
        rd_wren = 1'b1;
        wb_sel  = 2'b00;
        case (funct3)
          3'b000:  alu_op = (opcode == OP_R && f7_b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = f7_b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      OP_LOAD: begin
        rd_wren = 1'b1;
        wb_sel  = 2'b11;
      end
      OP_STORE: begin
        mem_wren = 1'b1;
      end
      OP_BRANCH: begin
        op1 = i_pc;
        if (funct3[2:1] == 2'b01) illegal = 1'b1;
        else                      pc_sel  = br_taken;
      end
      OP_JAL: begin
        op1     = i_pc;
        pc_sel  = 1'b1;
        rd_wren = 1'b1;
        wb_sel  = 2'b10;
      end
      OP_JALR: begin
        jalr    = 1'b1;
        pc_sel  = 1'b1;
        rd_wren = 1'b1;
        wb_sel  = 2'b10;
      end
      OP_LUI: begin
        op1     = '0;
        rd_wren = 1'b1;
        wb_sel  = 2'b00;
      end
      OP_AUIPC: begin
        op1     = i_pc;
        rd_wren = 1'b1;
        wb_sel  = 2'b00;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // ALU proper. Shift amount is the low five bits of op2.
  always_comb begin
    case (alu_op)
      ALU_ADD:  alu_res = op1 + op2;
      ALU_SUB:  alu_res = op1 - op2;
      ALU_SLL:  alu_res = op1 << op2[4:0];
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
      ALU_XOR:  alu_res = op1 ^ op2;
      ALU_SRL:  alu_res = op1 >> op2[4:0];
      ALU_SRA:  alu_res = $unsigned($signed(op1) >>> op2[4:0]);
      ALU_OR:   alu_res = op1 | op2;
      default:  alu_res = op1 & op2;
    endcase
  end

  // JALR targets drop bit 0; illegal instructions report a zero result.
  always_comb begin
    if (illegal)
      alu_final = '0;
    else if (jalr)
      alu_final = {alu_res[XLEN-1:1], 1'b0};
    else
      alu_final = alu_res;
  end

  // Output register. Captures every cycle; side-effecting enables are
  // gated by i_valid so a bubble can never write or redirect.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid    <= 1'b0;
      o_alu_data <= '0;
      o_pc_sel   <= 1'b0;
      o_rd_wren  <= 1'b0;
      o_mem_wren <= 1'b0;
      o_wb_sel   <= 2'b00;
      o_br_less  <= 1'b0;
      o_br_equal <= 1'b0;
      o_illegal  <= 1'b0;
`ifdef RV32I_ALU_ZERO_EN
      o_alu_zero <= 1'b0;
`endif
    end else begin
      o_valid    <= i_valid;
      o_alu_data <= alu_final;
      o_pc_sel   <= pc_sel & i_valid;
      o_rd_wren  <= rd_wren & i_valid;
      o_mem_wren <= mem_wren & i_valid;
      o_wb_sel   <= wb_sel;
      o_br_less  <= br_less;
      o_br_equal <= br_equal;
      o_illegal  <= illegal;
`ifdef RV32I_ALU_ZERO_EN
      o_alu_zero <= (alu_final == '0);
`endif
    end
  end

endmodule

// File: tb/tb_rv32i_exec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv32i_exec_ctrl
//   Directed bench for rv32i_exec_ctrl. Each step drives one instruction on
//   the falling edge and pushes the hand-derived expected outputs onto a
//   scoreboard queue; one cycle later the registered outputs are popped and
//   compared field by field.
// ---------------------------------------------------------------------------
module tb_rv32i_exec_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic [31:0] i_inst, i_pc, i_rs1_data, i_rs2_data, i_imm;
  logic        o_valid;
  logic [31:0] o_alu_data;
  logic        o_pc_sel, o_rd_wren, o_mem_wren;
  logic [1:0]  o_wb_sel;
  logic        o_br_less, o_br_equal, o_illegal;
`ifdef RV32I_ALU_ZERO_EN
  logic        o_alu_zero;
`endif

  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic        pc_sel;
    logic        rd_wren;
    logic        mem_wren;
    logic [1:0]  wb;
    logic        less;
    logic        equal;
    logic        illegal;
    logic        zero;
  } exp_t;

  exp_t scoreboard[$];
  int   checks = 0;
  int   errors = 0;

  rv32i_exec_ctrl #(.XLEN(32)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .i_inst     (i_inst),
    .i_pc       (i_pc),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_imm      (i_imm),
    .o_valid    (o_valid),
    .o_alu_data (o_alu_data),
    .o_pc_sel   (o_pc_sel),
    .o_rd_wren  (o_rd_wren),
    .o_mem_wren (o_mem_wren),
    .o_wb_sel   (o_wb_sel),
    .o_br_less  (o_br_less),
    .o_br_equal (o_br_equal),
`ifdef RV32I_ALU_ZERO_EN
    .o_alu_zero (o_alu_zero),
`endif
    .o_illegal  (o_illegal)
  );

  // Free-running 10-unit clock.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Drive one set of inputs on the falling edge.
  task automatic apply_stimulus(input logic v, input logic [31:0] inst,
                                input logic [31:0] pc, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [31:0] imm);
    @(negedge i_clk);
    i_valid    = v;
    i_inst     = inst;
    i_pc       = pc;
    i_rs1_data = rs1;
    i_rs2_data = rs2;
    i_imm      = imm;
  endtask

  // Queue the expected outputs of the instruction just driven.
  task automatic push_expect(input logic v, input logic [31:0] alu,
                             input logic pc_sel, input logic rd_wren,
                             input logic mem_wren, input logic [1:0] wb,
                             input logic less, input logic equal,
                             input logic illegal);
    exp_t e;
    e.valid = v;     e.alu = alu;       e.pc_sel = pc_sel;
    e.rd_wren = rd_wren; e.mem_wren = mem_wren; e.wb = wb;
    e.less = less;   e.equal = equal;   e.illegal = illegal;
    e.zero = (alu == 32'h0);
    scoreboard.push_back(e);
  endtask

  // Reset clears every output register, including the zero flag.
  task automatic push_reset_expect();
    exp_t e;
    e.valid = 0; e.alu = 0; e.pc_sel = 0; e.rd_wren = 0; e.mem_wren = 0;
    e.wb = 0; e.less = 0; e.equal = 0; e.illegal = 0; e.zero = 0;
    scoreboard.push_back(e);
  endtask

  task automatic check_field(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Wait for the capturing edge, then pop and compare away from the edge.
  task automatic check_output(input string name);
    exp_t e;
    @(posedge i_clk);
    #1;
    if (scoreboard.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: scoreboard empty, observed output with no expectation", name);
    end else begin
      e = scoreboard.pop_front();
      check_field({name, ".valid"},    {31'b0, o_valid},    {31'b0, e.valid});
      check_field({name, ".alu"},      o_alu_data,          e.alu);
      check_field({name, ".pc_sel"},   {31'b0, o_pc_sel},   {31'b0, e.pc_sel});
      check_field({name, ".rd_wren"},  {31'b0, o_rd_wren},  {31'b0, e.rd_wren});
      check_field({name, ".mem_wren"}, {31'b0, o_mem_wren}, {31'b0, e.mem_wren});
      check_field({name, ".wb_sel"},   {30'b0, o_wb_sel},   {30'b0, e.wb});
      check_field({name, ".br_less"},  {31'b0, o_br_less},  {31'b0, e.less});
      check_field({name, ".br_equal"}, {31'b0, o_br_equal}, {31'b0, e.equal});
      check_field({name, ".illegal"},  {31'b0, o_illegal},  {31'b0, e.illegal});
`ifdef RV32I_ALU_ZERO_EN
      check_field({name, ".alu_zero"}, {31'b0, o_alu_zero}, {31'b0, e.zero});
`endif
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_inst = 0; i_pc = 0; i_rs1_data = 0; i_rs2_data = 0; i_imm = 0;

    // Reset with random inputs for two cycles.
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                     $urandom, $urandom);
      push_reset_expect();
      check_output("reset");
    end

    // Release reset on the next drive.
    apply_stimulus(1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 32'h0);
    i_rst_n = 1'b1;
    push_expect(1, 32'd12, 0, 1, 0, 2'b00, 1, 0, 0);
    check_output("add");

    apply_stimulus(1, 32'h402081B3, 32'h0, 32'd3, 32'd5, 32'h0);
    push_expect(1, 32'hFFFFFFFE, 0, 1, 0, 2'b00, 1, 0, 0);
    check_output("sub");

    apply_stimulus(1, 32'h4020D1B3, 32'h0, 32'h80000000, 32'd4, 32'h0);
    push_expect(1, 32'hF8000000, 0, 1, 0, 2'b00, 1, 0, 0);
    check_output("sra");

    apply_stimulus(1, 32'h0020D1B3, 32'h0, 32'h80000000, 32'd4, 32'h0);
    push_expect(1, 32'h08000000, 0, 1, 0, 2'b00, 1, 0, 0);
    check_output("srl");

    apply_stimulus(1, 32'h00508093, 32'h0, 32'd10, 32'd0, 32'd5);
    push_expect(1, 32'd15, 0, 1, 0, 2'b00, 0, 0, 0);
    check_output("addi");

    apply_stimulus(1, 32'h4040D093, 32'h0, 32'h80000000, 32'd0, 32'h00000404);
    push_expect(1, 32'hF8000000, 0, 1, 0, 2'b00, 1, 0, 0);
    check_output("srai");

    apply_stimulus(1, 32'h0020C063, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20);
    push_expect(1, 32'h120, 1, 0, 0, 2'b01, 1, 0, 0);
    check_output("blt");

    apply_stimulus(1, 32'h0020E063, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20);
    push_expect(1, 32'h120, 0, 0, 0, 2'b01, 0, 0, 0);
    check_output("bltu");

    apply_stimulus(1, 32'h0020A063, 32'h100, 32'd9, 32'd9, 32'h20);
    push_expect(1, 32'h0, 0, 0, 0, 2'b01, 0, 1, 1);
    check_output("br_f3_010");

    apply_stimulus(1, 32'h000080E7, 32'h0, 32'h203, 32'h0, 32'h0);
    push_expect(1, 32'h202, 1, 1, 0, 2'b10, 0, 0, 0);
    check_output("jalr");

    apply_stimulus(1, 32'h000000EF, 32'h40, 32'h0, 32'h0, 32'hFFFFFFF8);
    push_expect(1, 32'h38, 1, 1, 0, 2'b10, 0, 1, 0);
    check_output("jal");

    apply_stimulus(1, 32'h0020A223, 32'h0, 32'h1000, 32'h55, 32'd4);
    push_expect(1, 32'h1004, 0, 0, 1, 2'b01, 0, 0, 0);
    check_output("sw");

    apply_stimulus(1, 32'h0000A083, 32'h0, 32'h2000, 32'h0, 32'hFFFFFFFC);
    push_expect(1, 32'h1FFC, 0, 1, 0, 2'b11, 0, 0, 0);
    check_output("lw");

    apply_stimulus(1, 32'h123450B7, 32'h0, 32'h111, 32'h111, 32'h12345000);
    push_expect(1, 32'h12345000, 0, 1, 0, 2'b00, 0, 1, 0);
    check_output("lui");

    apply_stimulus(1, 32'h00001097, 32'h100, 32'h0, 32'h0, 32'h1000);
    push_expect(1, 32'h1100, 0, 1, 0, 2'b00, 0, 1, 0);
    check_output("auipc");

    apply_stimulus(1, 32'h0000007F, 32'h0, 32'd1, 32'd2, 32'h0);
    push_expect(1, 32'h0, 0, 0, 0, 2'b01, 1, 0, 1);
    check_output("illegal_op");

    apply_stimulus(0, 32'h002081B3, 32'h0, 32'd5, 32'd7, 32'h0);
    push_expect(0, 32'd12, 0, 0, 0, 2'b00, 1, 0, 0);
    check_output("bubble_add");

    // A bubble on a taken JAL must not redirect.
    apply_stimulus(0, 32'h000000EF, 32'h40, 32'h0, 32'h0, 32'hFFFFFFF8);
    push_expect(0, 32'h38, 0, 0, 0, 2'b10, 0, 1, 0);
    check_output("bubble_jal");

    // Reset asserted over a valid instruction clears the outputs again.
    apply_stimulus(1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 32'h0);
    i_rst_n = 1'b0;
    push_reset_expect();
    check_output("reset_prio");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_exec_ctrl.md
Name: rv32i_exec_ctrl

Overview:
- RV32I execute-stage block: instruction decode (control), branch comparator and ALU merged into one unit.
- Sits between regfile/immgen and LSU/writeback of the single-cycle core.
- Decode, compare and ALU evaluate combinationally; all outputs are captured in an output register, so results appear 1 cycle after the inputs.

Parameters:
- XLEN, 32, datapath width (only 32 supported).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_valid  in  1  inputs valid this cycle.
- i_inst  in  32  instruction word.
- i_pc  in  32  PC of instruction.
- i_rs1_data  in  32  rs1 value.
- i_rs2_data  in  32  rs2 value.
- i_imm  in  32  sign-extended immediate from immgen.
- o_valid  out  1  registered i_valid.
- o_alu_data  out  32  ALU result (address, target or writeback value).
- o_pc_sel  out  1  1 = next PC is o_alu_data (taken branch/JAL/JALR).
- o_rd_wren  out  1  regfile write enable.
- o_mem_wren  out  1  store enable.
- o_wb_sel  out  2  00 ALU, 01 none, 10 PC+4, 11 load data.
- o_br_less  out  1  comparator less-than.
- o_br_equal  out  1  comparator equal.
- o_illegal  out  1  unsupported opcode/funct.

Behaviour:
- Reset: when i_rst_n=0 at a rising edge, every output register becomes 0. Reset has priority over capture.
- Capture: every non-reset edge loads the decoded/computed values, regardless of i_valid.
  - o_valid follows i_valid.
  - When i_valid=0, o_rd_wren, o_mem_wren and o_pc_sel are forced to 0.
- Opcodes:
  - R=0110011: op1=rs1, op2=rs2, wb 00, rd_wren.
  - I=0010011: op1=rs1, op2=imm, wb 00, rd_wren.
  - LOAD=0000011: rs1+imm, wb 11, rd_wren.
  - STORE=0100011: rs1+imm, mem_wren, wb 01.
  - BRANCH=1100011: pc+imm, wb 01, pc_sel=taken.
  - JAL=1101111: pc+imm, pc_sel=1, wb 10, rd_wren.
  - JALR=1100111: (rs1+imm) with bit0 cleared, pc_sel=1, wb 10, rd_wren.
  - LUI=0110111: 0+imm, wb 00, rd_wren.
  - AUIPC=0010111: pc+imm, wb 00, rd_wren.
- ALU ops, selected from funct3/funct7[5]:
  - ADD/SUB: SUB only for R-type with f7[5]=1.
  - SLL, SLT (signed), SLTU, XOR, SRL, SRA (f7[5]=1, also for I-type shifts), OR, AND.
  - Shift amount is op2[4:0]. Arithmetic wraps modulo 2^32. SLT/SLTU return 0 or 1.
- Comparator (always rs1 vs rs2):
  - equal = (rs1==rs2).
  - less is unsigned for funct3 110/111, signed otherwise.
- Branch taken, by funct3:
  - 000 beq: equal.
  - 001 bne: !equal.
  - 100 blt, 110 bltu: less.
  - 101 bge, 111 bgeu: !less.
  - 010/011: illegal.
- rd=x0: o_rd_wren is still asserted; regfile ignores writes to x0.
- Illegal cases:
  - Unknown opcode.
  - Branch funct3 010/011.
  - Response: o_illegal=1, rd_wren=mem_wren=pc_sel=0, wb 01, o_alu_data=0.

Optional Feature:
- RV32I_ALU_ZERO_EN defined: adds output o_alu_zero (1 bit, registered, reset 0), equal to (o_alu_data==0) for the same captured instruction.
- Undefined: the port is absent and behaviour is otherwise identical.

Test Plan:
- Reset held low 2 cycles with random inputs -> all outputs 0. Release, ADD x3 (0x002081B3), rs1=5, rs2=7 -> next cycle o_alu_data=12, rd_wren=1, wb=00.
- SUB 0x402081B3, rs1=3, rs2=5 -> 0xFFFFFFFE. SRA rs1=0x80000000, rs2=4 -> 0xF8000000. SRL same inputs -> 0x08000000.
- BLT signed rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> pc_sel=1, alu=0x120. BLTU with the same operands -> pc_sel=0, br_less=0.
- JALR rs1=0x203, imm=0 -> alu=0x202, pc_sel=1, wb=10. JAL pc=0x40, imm=-8 -> alu=0x38.
- SW rs1=0x1000, imm=4 -> alu=0x1004, mem_wren=1, rd_wren=0. LUI imm=0x12345000 -> alu=0x12345000.
- Opcode 0x7F -> o_illegal=1, all enables 0. i_valid=0 with a valid ADD -> enables 0, o_valid=0.
